// File: rtl/seq_div_if.sv
// Start/done handshake between the control FSM (master) and the sequential divider (slave).
// SEQ_DIV_DIVU_EN adds the divu select, which is sampled together with start.
interface seq_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIV_DIVU_EN
  logic             divu;
`endif
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef SEQ_DIV_DIVU_EN
  modport master (output start, dividend, divisor, divu, input busy, done, div_zero, hi, lo);
  modport slave  (input start, dividend, divisor, divu, output busy, done, div_zero, hi, lo);
`else
  modport master (output start, dividend, divisor, input busy, done, div_zero, hi, lo);
  modport slave  (input start, dividend, divisor, output busy, done, div_zero, hi, lo);
`endif
endinterface

// File: rtl/seq_div_unit.sv
// Multicycle restoring divider with MIPS DIV semantics: quotient to lo, remainder to hi.
// Optional unsigned mode (divu input) is enabled with SEQ_DIV_DIVU_EN.
module seq_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  seq_div_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             div_by_zero;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

`ifdef SEQ_DIV_DIVU_EN
  assign signed_op = ~bus.divu;
`else
  assign signed_op = 1'b1;
`endif

  assign a_neg       = signed_op & bus.dividend[WIDTH-1];
  assign b_neg       = signed_op & bus.divisor[WIDTH-1];
  assign a_abs       = a_neg ? -bus.dividend : bus.dividend;
  assign b_abs       = b_neg ? -bus.divisor : bus.divisor;
  assign div_by_zero = (bus.divisor == '0);

  // The shifted partial remainder needs WIDTH+1 bits once the divisor's MSB is set.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = div_by_zero ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != StIdle);
    bus.done = (state_q == StDone);
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          dz_d      = div_by_zero;
          quo_d     = a_abs;
          rem_d     = '0;
          dvs_d     = b_abs;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = CntW'(WIDTH);
        end
      end
      StCalc: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
      end
      StFix: begin
        lo_d = neg_quo_q ? -quo_q : quo_q;
        hi_d = neg_rem_q ? -rem_q : rem_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_seq_div_unit.sv
// Directed bench for seq_div_unit: a scoreboard queue holds expected results per operation.
module tb_seq_div_unit;
  localparam int unsigned W = 32;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_div_if #(.WIDTH(W)) bus ();

  seq_div_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t        sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_chk = 0;
  int          done_cnt = 0;

  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: 64-bit arithmetic avoids the INT_MIN / -1 overflow.
  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic u);
    longint la, lb, q, r;
    exp_t   e;
    if (b == '0) begin
      e = '{lo: m_lo, hi: m_hi, dz: 1'b1};
    end else begin
      la = u ? longint'({32'd0, a}) : longint'($signed(a));
      lb = u ? longint'({32'd0, b}) : longint'($signed(b));
      q  = la / lb;
      r  = la % lb;
      m_lo = q[31:0];
      m_hi = r[31:0];
      e = '{lo: m_lo, hi: m_hi, dz: 1'b0};
    end
    sb.push_back(e);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic u, input int restart_at);
    int   cyc;
    int   dc0;
    logic busy_ok;
    exp_t e;
    push_exp(a, b, u);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
`ifdef SEQ_DIV_DIVU_EN
    bus.divu     = u;
`endif
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    dc0     = done_cnt;
    cyc     = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == restart_at) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
    end while (bus.done !== 1'b1 && cyc < 100);
    bus.start = 1'b0;
    check({tag, " latency"}, cyc, (b == '0) ? 32'd1 : W + 2);
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " lo"}, bus.lo, e.lo);
      check({tag, " hi"}, bus.hi, e.hi);
      check({tag, " div_zero"}, {31'd0, bus.div_zero}, {31'd0, e.dz});
    end
    @(negedge clk);
    check({tag, " done pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " done count"}, done_cnt - dc0, 32'd1);
  endtask

  initial begin
    int dc0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef SEQ_DIV_DIVU_EN
    bus.divu     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst done", {31'd0, bus.done}, 32'd0);
    check("rst dz", {31'd0, bus.div_zero}, 32'd0);
    check("rst hi", bus.hi, 32'd0);
    check("rst lo", bus.lo, 32'd0);
    reset = 1'b1;

    run_op("100/7", 32'd100, 32'd7, 1'b0, 0);
    run_op("-7/2", 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run_op("7/-2", 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
    run_op("100/7 again", 32'd100, 32'd7, 1'b0, 0);
    run_op("x/0", 32'd12345, 32'd0, 1'b0, 0);
    run_op("20/6", 32'd20, 32'd6, 1'b0, 0);
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10);
    dc0 = done_cnt;
    repeat (40) @(negedge clk);
    check("ovf no extra done", done_cnt - dc0, 32'd0);
    run_op("max/min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 0);
    run_op("min/max", 32'h8000_0001, 32'h7FFF_FFFF, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      run_op("rand", $urandom, $urandom | 32'd1, 1'b0, 0);
    end

    // Abort an operation with an asynchronous reset mid-calculation.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    dc0   = done_cnt;
    reset = 1'b0;
    #1;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort hi", bus.hi, 32'd0);
    check("abort lo", bus.lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("abort no done", done_cnt - dc0, 32'd0);
    run_op("9/3", 32'd9, 32'd3, 1'b0, 0);

`ifdef SEQ_DIV_DIVU_EN
    run_op("divu", 32'hFFFF_FFFF, 32'd2, 1'b1, 0);
    run_op("div same", 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
